// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the handshaked ALU pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pipe_pkg;

  // Opcodes 0-3 keep the legacy 3-bit select encoding.
  typedef enum logic [3:0] {
    OP_FWD = 4'd0,
    OP_ADD = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SUB = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit positions inside FLAGS = {ILLEGAL, OVF, CARRY, ZERO}.
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_ILLEGAL = 3;

  // Pack individual flag bits into the FLAGS vector.
  function automatic logic [3:0] mk_flags(input logic zero, input logic carry,
                                          input logic ovf, input logic illegal);
    logic [3:0] f;
    f               = '0;
    f[FLAG_ZERO]    = zero;
    f[FLAG_CARRY]   = carry;
    f[FLAG_OVF]     = ovf;
    f[FLAG_ILLEGAL] = illegal;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: WIDTH cycles after start; done is high during the final step cycle.
// Backpressure: none; caller must not pulse start while a multiply is in flight.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc;

  // Load operands on start, otherwise perform one shift-add step per busy cycle.
  // The low half of prod holds the remaining multiplier bits; the high half accumulates.
  always_comb begin
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    acc     = '0;
    if (start) begin
      cnt_d   = CNT_W'(WIDTH);
      prod_d  = {{WIDTH{1'b0}}, b};
      mcand_d = a;
    end else if (cnt_q != '0) begin
      acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
             + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      prod_d = {acc, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  // The final step's product is presented combinationally so the caller can
  // register it on the same edge the counter reaches zero.
  always_comb begin
    done    = (cnt_q == CNT_W'(1));
    product = prod_d;
  end

  // Step counter, product accumulator and multiplicand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready channels; MUL (opcode 8) only when ALU_PIPE_MUL_EN is defined.
// Latency: 1 cycle for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: result held until OUT_READY; IN_READY only in IDLE or DONE with OUT_READY.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [3:0]       SELECT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic [3:0]       FLAGS,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             in_xfer;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHAMT_W-1:0] shamt;
  logic             alu_carry, alu_ovf, alu_ill;

`ifdef ALU_PIPE_MUL_EN
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .start   (mul_start),
    .a       (DATA1),
    .b       (DATA2),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Single-cycle datapath for every opcode except MUL; unknown codes report ILLEGAL.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    add_w     = {1'b0, DATA1} + {1'b0, DATA2};
    sub_w     = {1'b0, DATA1} - {1'b0, DATA2};
    shamt     = DATA2[SHAMT_W-1:0];
    case (opcode_e'(SELECT))
      OP_FWD: alu_res = DATA2;
      OP_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
        alu_ovf   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (alu_res[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: alu_res = DATA1 & DATA2;
      OP_OR:  alu_res = DATA1 | DATA2;
      OP_SUB: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = ~sub_w[WIDTH];
        alu_ovf   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (alu_res[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_SLL: alu_res = DATA1 << shamt;
      OP_SRL: alu_res = DATA1 >> shamt;
      OP_SRA: alu_res = $signed(DATA1) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
    alu_flags = mk_flags(alu_res == '0, alu_carry, alu_ovf, alu_ill);
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    IN_READY  = RESET_N && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY));
    OUT_VALID = (state_q == ST_DONE);
    RESULT    = result_q;
    FLAGS     = flags_q;
    in_xfer   = IN_VALID && IN_READY;
`ifdef ALU_PIPE_MUL_EN
    is_mul    = (SELECT == OP_MUL);
    mul_start = in_xfer && is_mul;
`endif
  end

  // Next-state: accept new ops, finish the multiply, or drain the held result.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
`ifdef ALU_PIPE_MUL_EN
      state_d = is_mul ? ST_BUSY : ST_DONE;
`else
      state_d = ST_DONE;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
`ifdef ALU_PIPE_MUL_EN
        ST_BUSY: if (mul_done) state_d = ST_DONE;
`endif
        ST_DONE: if (OUT_READY) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output register loads: ALU result on a non-MUL transfer, product on the final MUL step.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_PIPE_MUL_EN
    if (in_xfer && !is_mul) begin
      result_d = alu_res;
      flags_d  = alu_flags;
    end else if ((state_q == ST_BUSY) && mul_done) begin
      result_d = mul_product[WIDTH-1:0];
      flags_d  = mk_flags(mul_product[WIDTH-1:0] == '0,
                          |mul_product[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
    end
`else
    if (in_xfer) begin
      result_d = alu_res;
      flags_d  = alu_flags;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8), both MUL build variants.
// Latency: checks 1-cycle non-MUL and WIDTH+1-cycle MUL result timing.
// Backpressure: checks hold behaviour under OUT_READY=0 and same-cycle re-accept.
module tb_alu_pipe;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [3:0] SELECT;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] RESULT;
  logic [3:0] FLAGS;
  logic       OUT_VALID;
  logic       OUT_READY;

  int n_tests;
  int n_fail;

  alu_pipe #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .SELECT    (SELECT),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .RESULT    (RESULT),
    .FLAGS     (FLAGS),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] d1, input logic [7:0] d2);
    SELECT   = sel;
    DATA1    = d1;
    DATA2    = d2;
    IN_VALID = 1'b1;
  endtask

  // Stream table: opcode, operands, expected result and flags {ILL,OVF,CARRY,ZERO}.
  logic [3:0] s_sel [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd4};
  logic [7:0] s_d1  [10] = '{8'h11, 8'h10, 8'hF0, 8'h0F, 8'h05, 8'h81, 8'h81, 8'h7F, 8'h7F, 8'h10};
  logic [7:0] s_d2  [10] = '{8'h22, 8'h20, 8'h3C, 8'h30, 8'h07, 8'h01, 8'h04, 8'h02, 8'h01, 8'h10};
  logic [7:0] s_res [10] = '{8'h22, 8'h30, 8'h30, 8'h3F, 8'hFE, 8'h02, 8'h08, 8'h1F, 8'h80, 8'h00};
  logic [3:0] s_flg [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3};

  int stale;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RESET_N   = 1'b0;
    DATA1     = '0;
    DATA2     = '0;
    SELECT    = '0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_result", RESULT, 8'h00);
    chk("rst_flags", FLAGS, 4'h0);
    tick();
    tick();
    RESET_N = 1'b1;
    #1;
    chk("rst_in_ready", IN_READY, 1'b1);

    // ADD FF+01: wraps to zero with carry, no signed overflow
    drive(4'd1, 8'hFF, 8'h01);
    tick();
    IN_VALID = 1'b0;
    chk("add_valid", OUT_VALID, 1'b1);
    chk("add_result", RESULT, 8'h00);
    chk("add_flags", FLAGS, 4'b0011);
    tick();
    chk("add_drain", OUT_VALID, 1'b0);

    // SUB 80-01: signed overflow, no borrow
    drive(4'd4, 8'h80, 8'h01);
    tick();
    IN_VALID = 1'b0;
    chk("sub_result", RESULT, 8'h7F);
    chk("sub_flags", FLAGS, 4'b0110);
    tick();

    // SRA 90 by 0B (amount 3)
    drive(4'd7, 8'h90, 8'h0B);
    tick();
    chk("sra_result", RESULT, 8'hF2);
    chk("sra_flags", FLAGS, 4'b0000);
    // SLL by 0 (upper DATA2 bit ignored) returns DATA1
    drive(4'd5, 8'h5A, 8'h08);
    tick();
    chk("sll0_result", RESULT, 8'h5A);
    // SRA by WIDTH-1 yields all sign bits
    drive(4'd7, 8'h80, 8'h07);
    tick();
    chk("sra7_result", RESULT, 8'hFF);
    // SRL by WIDTH-1
    drive(4'd6, 8'h80, 8'h07);
    tick();
    IN_VALID = 1'b0;
    chk("srl7_result", RESULT, 8'h01);
    tick();

`ifdef ALU_PIPE_MUL_EN
    // MUL 0F*11 = 00FF
    drive(4'd8, 8'h0F, 8'h11);
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mul1_busy_in_ready", IN_READY, 1'b0);
      chk("mul1_busy_out_valid", OUT_VALID, 1'b0);
      tick();
    end
    chk("mul1_valid", OUT_VALID, 1'b1);
    chk("mul1_result", RESULT, 8'hFF);
    chk("mul1_flags", FLAGS, 4'b0000);
    // Back-to-back: 10*10 = 0100 accepted in the DONE cycle
    drive(4'd8, 8'h10, 8'h10);
    #1;
    chk("mul2_accept", IN_READY, 1'b1);
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mul2_busy_in_ready", IN_READY, 1'b0);
      tick();
    end
    chk("mul2_valid", OUT_VALID, 1'b1);
    chk("mul2_result", RESULT, 8'h00);
    chk("mul2_flags", FLAGS, 4'b0011);
    tick();
`else
    // Opcode 8 without the multiplier behaves as an illegal opcode
    drive(4'd8, 8'h0F, 8'h11);
    tick();
    IN_VALID = 1'b0;
    chk("mul_off_valid", OUT_VALID, 1'b1);
    chk("mul_off_result", RESULT, 8'h00);
    chk("mul_off_flags", FLAGS, 4'b1001);
    tick();
`endif

    // Backpressure: OR result held for 5 cycles while the next op waits
    OUT_READY = 1'b0;
    drive(4'd3, 8'hA0, 8'h05);
    tick();
    drive(4'd1, 8'h01, 8'h02);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", OUT_VALID, 1'b1);
      chk("hold_result", RESULT, 8'hA5);
      chk("hold_flags", FLAGS, 4'h0);
      chk("hold_in_ready", IN_READY, 1'b0);
      tick();
    end
    OUT_READY = 1'b1;
    #1;
    chk("release_in_ready", IN_READY, 1'b1);
    tick();
    chk("release_valid", OUT_VALID, 1'b1);
    chk("release_result", RESULT, 8'h03);

    // Stream of 10 non-MUL ops, one result per cycle in order
    for (int i = 0; i < 10; i++) begin
      drive(s_sel[i], s_d1[i], s_d2[i]);
      #1;
      chk("stream_in_ready", IN_READY, 1'b1);
      tick();
      chk("stream_valid", OUT_VALID, 1'b1);
      chk("stream_result", RESULT, s_res[i]);
      chk("stream_flags", FLAGS, s_flg[i]);
    end
    IN_VALID = 1'b0;
    tick();

    // Illegal opcode
    drive(4'hC, 8'h12, 8'h34);
    tick();
    IN_VALID = 1'b0;
    chk("illegal_result", RESULT, 8'h00);
    chk("illegal_flags", FLAGS, 4'b1001);
    tick();

    // Reset in flight: mid-MUL when the multiplier exists, else with a held result
`ifdef ALU_PIPE_MUL_EN
    drive(4'd8, 8'h0F, 8'h11);
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    tick();
`else
    OUT_READY = 1'b0;
    drive(4'd1, 8'h03, 8'h04);
    tick();
    IN_VALID = 1'b0;
`endif
    RESET_N = 1'b0;
    #1;
    chk("midrst_out_valid", OUT_VALID, 1'b0);
    chk("midrst_result", RESULT, 8'h00);
    tick();
    RESET_N   = 1'b1;
    OUT_READY = 1'b1;
    #1;
    chk("postrst_in_ready", IN_READY, 1'b1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (OUT_VALID !== 1'b0) stale++;
    end
    chk("postrst_no_stale", stale, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
